// File: rtl/areg_pkg.sv
// Shared definitions for the 4-bit load/reset/shift/hold register and its
// sequencing controller: control-code constants and controller FSM states.
package areg_pkg;

    // Control codes decoded by the register, carried as {c1,c0}
    localparam logic [1:0] AREG_LOAD  = 2'b00;
    localparam logic [1:0] AREG_RESET = 2'b01;
    localparam logic [1:0] AREG_SHIFT = 2'b10;
    localparam logic [1:0] AREG_HOLD  = 2'b11;

    // Sequencing controller states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        SHIFT  = 2'b10,
        FINISH = 2'b11
    } areg_state_t;

    // Code issued while the controller is in the load phase
    function automatic logic [1:0] load_code(input logic clr);
        return clr ? AREG_RESET : AREG_LOAD;
    endfunction

endpackage

// File: rtl/areg_seq_cnt.sv
// Loadable CNT_W-bit down-counter with zero flag. Decrement saturates at 0.
module areg_seq_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] init,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    // Load has priority; decrement never goes below zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= init;
        end else if (dec && (value != '0)) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/areg_seq.sv
// Sequencing controller for the 4-bit load/reset/shift/hold register.
// Accepts one job per start/ready handshake: load (or clear), cnt shifts,
// then hold with a one-cycle done pulse.
// Optional feature macro: AREG_SEQ_SNAP_EN (snapshot of q into result at
// job completion); when undefined, result is tied to zero.
module areg_seq
    import areg_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             clr,
    input  logic [CNT_W-1:0] cnt,
    input  logic [3:0]       d_in,
    output logic             ready,
    output logic             c1,
    output logic             c0,
    output logic [3:0]       d_out,
    output logic             done,
    input  logic [3:0]       q,
    output logic [3:0]       result
);

    areg_state_t      state_q;
    areg_state_t      state_d;
    logic             clr_q;
    logic             accept;
    logic [CNT_W-1:0] rem;
    logic             rem_zero;
    logic [1:0]       code;

    assign accept = (state_q == IDLE) && start;

    areg_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .dec   (state_q == SHIFT),
        .init  (cnt),
        .value (rem),
        .zero  (rem_zero)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job capture: word and clear flag are sampled only when a job is accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_out <= '0;
            clr_q <= 1'b0;
        end else if (accept) begin
            d_out <= d_in;
            clr_q <= clr;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d = state_q;
        code    = AREG_HOLD;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                code    = load_code(clr_q);
                state_d = rem_zero ? FINISH : SHIFT;
            end
            SHIFT: begin
                code = AREG_SHIFT;
                if (rem == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {c1, c0} = code;

`ifdef AREG_SEQ_SNAP_EN
    // Snapshot of the register contents on the edge leaving FINISH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result <= '0;
        end else if (state_q == FINISH) begin
            result <= q;
        end
    end
`else
    logic q_unused;
    assign q_unused = ^q;
    assign result   = '0;
`endif

endmodule

// File: tb/tb_areg_seq.sv
// Bench for areg_seq wired to a behavioural 4-bit load/reset/shift/hold
// register (shift right, zero fill). Table-driven jobs, reset corner cases
// and random jobs checked against a queue-based sequence model.
module tb_areg_seq;
    import areg_pkg::*;

    localparam int unsigned CNT_W = 3;

    typedef struct {
        logic        clr;
        logic [2:0]  cnt;
        logic [3:0]  d;
        bit          poke;
        bit          chain;
        logic [3:0]  exp_q;
        int unsigned exp_len;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             clr;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       d_in;
    logic             ready;
    logic             c1;
    logic             c0;
    logic [3:0]       d_out;
    logic             done;
    logic [3:0]       q;
    logic [3:0]       result;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clock = ~clock;

    areg_seq #(
        .CNT_W (CNT_W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .clr    (clr),
        .cnt    (cnt),
        .d_in   (d_in),
        .ready  (ready),
        .c1     (c1),
        .c0     (c0),
        .d_out  (d_out),
        .done   (done),
        .q      (q),
        .result (result)
    );

    // The register being sequenced
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= 4'b0000;
        end else begin
            case ({c1, c0})
                2'b00:   q <= d_out;
                2'b01:   q <= 4'b0000;
                2'b10:   q <= {1'b0, q[3:1]};
                default: q <= q;
            endcase
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] snap(input logic [3:0] v);
`ifdef AREG_SEQ_SNAP_EN
        return v;
`else
        return 4'b0000 & v;
`endif
    endfunction

    // Runs one job starting at the negedge of an IDLE cycle; returns to the
    // negedge of the IDLE cycle after done. poke keeps start high with junk
    // values during the job; chain leaves start high through FINISH.
    task automatic run_job(input logic cl, input logic [2:0] n, input logic [3:0] d,
                           input bit poke, input bit chain, output int unsigned done_at);
        logic [1:0]  codes[$];
        logic [3:0]  qexp;
        logic [3:0]  final_q;
        int unsigned ndone;
        codes.push_back(cl ? 2'b01 : 2'b00);
        for (int unsigned k = 0; k < 32'(n); k++) codes.push_back(2'b10);
        codes.push_back(2'b11);
        final_q = cl ? 4'b0000 : (d >> n);
        done_at = 0;
        ndone   = 0;

        chk("ready_before_job", 16'(ready), 16'd1);
        start = 1'b1; clr = cl; cnt = n; d_in = d;
        @(posedge clock); @(negedge clock);
        start = poke; clr = ~cl; cnt = ~n; d_in = ~d;
        for (int unsigned j = 0; j < codes.size(); j++) begin
            chk("code", 16'({c1, c0}), 16'(codes[j]));
            chk("ready_busy", 16'(ready), 16'd0);
            chk("done", 16'(done), 16'(j == codes.size() - 1));
            chk("d_out_busy", 16'(d_out), 16'(d));
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = j + 1;
            end
            if (j >= 1) begin
                qexp = cl ? 4'b0000 : 4'(d >> (j - 1));
                chk("q_during_job", 16'(q), 16'(qexp));
            end
            if (j == codes.size() - 1) start = chain;
            @(posedge clock); @(negedge clock);
        end
        chk("done_count", 16'(ndone), 16'd1);
        chk("code_idle", 16'({c1, c0}), 16'(2'b11));
        chk("ready_idle", 16'(ready), 16'd1);
        chk("done_idle", 16'(done), 16'd0);
        chk("d_out_kept", 16'(d_out), 16'(d));
        chk("result", 16'(result), 16'(snap(final_q)));
    endtask

    vec_t        vecs[7];
    int unsigned got_len;

    initial begin
        reset = 1'b1; start = 1'b0; clr = 1'b0; cnt = '0; d_in = '0;

        vecs[0] = '{1'b0, 3'd0, 4'b1011, 1'b0, 1'b0, 4'b1011, 2};
        vecs[1] = '{1'b0, 3'd3, 4'b0001, 1'b0, 1'b0, 4'b0000, 5};
        vecs[2] = '{1'b1, 3'd2, 4'b1111, 1'b0, 1'b0, 4'b0000, 4};
        vecs[3] = '{1'b0, 3'd3, 4'b0110, 1'b1, 1'b1, 4'b0000, 5};
        vecs[4] = '{1'b0, 3'd1, 4'b1000, 1'b0, 1'b0, 4'b0100, 3};
        vecs[5] = '{1'b0, 3'd7, 4'b1111, 1'b0, 1'b0, 4'b0000, 9};
        vecs[6] = '{1'b0, 3'd2, 4'b1100, 1'b0, 1'b0, 4'b0011, 4};

        // Reset state
        @(negedge clock); @(negedge clock);
        chk("rst_code", 16'({c1, c0}), 16'(2'b11));
        chk("rst_ready", 16'(ready), 16'd1);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_d_out", 16'(d_out), 16'd0);
        chk("rst_result", 16'(result), 16'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed jobs
        for (int unsigned i = 0; i < 7; i++) begin
            run_job(vecs[i].clr, vecs[i].cnt, vecs[i].d, vecs[i].poke, vecs[i].chain, got_len);
            chk("vec_len", 16'(got_len), 16'(vecs[i].exp_len));
            chk("vec_q", 16'(q), 16'(vecs[i].exp_q));
            chk("vec_result", 16'(result), 16'(snap(vecs[i].exp_q)));
        end

        // Reset asserted mid-SHIFT with cnt=5
        start = 1'b1; clr = 1'b0; cnt = 3'd5; d_in = 4'b1010;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        chk("pre_rst_code", 16'({c1, c0}), 16'(2'b10));
        reset = 1'b1;
        #1;
        chk("mid_rst_code", 16'({c1, c0}), 16'(2'b11));
        chk("mid_rst_ready", 16'(ready), 16'd1);
        chk("mid_rst_done", 16'(done), 16'd0);
        chk("mid_rst_d_out", 16'(d_out), 16'd0);
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            chk("post_rst_done", 16'(done), 16'd0);
            chk("post_rst_code", 16'({c1, c0}), 16'(2'b11));
            chk("post_rst_ready", 16'(ready), 16'd1);
            @(posedge clock); @(negedge clock);
        end

        // Random jobs
        for (int unsigned i = 0; i < 40; i++) begin
            logic       r_clr;
            logic [2:0] r_cnt;
            logic [3:0] r_d;
            bit         r_poke;
            bit         r_chain;
            r_clr   = ($urandom_range(0, 3) == 0);
            r_cnt   = 3'($urandom_range(0, 7));
            r_d     = 4'($urandom);
            r_poke  = 1'($urandom_range(0, 1));
            r_chain = (i != 39) && ($urandom_range(0, 1) == 1);
            run_job(r_clr, r_cnt, r_d, r_poke, r_chain, got_len);
            chk("rand_len", 16'(got_len), 16'(32'(r_cnt) + 2));
        end
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
